// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module : pattern_pkg
// Brief  : Shared types and constants for the serial pattern TX/detector pair
// Rev    : 1.0
// ============================================================================
package pattern_pkg;

    localparam int PATTERN_WIDTH = 5;

    function automatic int bit_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int BIT_CNT_W = bit_cnt_w(PATTERN_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pattern_tx_if.sv
`default_nettype none
// ============================================================================
// Module : pattern_tx_if
// Brief  : Control/serial bundle of the pattern transmitter
// Rev    : 1.0
// ============================================================================
interface pattern_tx_if
    import pattern_pkg::*;
#(
    parameter int WIDTH    = PATTERN_WIDTH,
    parameter int REPEAT_W = 4
);
    logic                load;
    logic [WIDTH-1:0]    patternIn;
    logic [REPEAT_W-1:0] repeat_cnt;
    logic                start;
    logic                abort;
    logic                serial_out;
    logic                serial_valid;
    logic                busy;
    logic                done;

    modport master (
        output load, patternIn, repeat_cnt, start, abort,
        input  serial_out, serial_valid, busy, done
    );

    modport slave (
        input  load, patternIn, repeat_cnt, start, abort,
        output serial_out, serial_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pattern_tx_shreg.sv
`default_nettype none
// ============================================================================
// Module : pattern_tx_shreg
// Brief  : Loadable pattern register with bit-index select and MSB restart
// Rev    : 1.0
// ============================================================================
module pattern_tx_shreg
    import pattern_pkg::*;
#(
    parameter int WIDTH = PATTERN_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_restart,
    input  logic             i_step,
    output logic             o_bit_nxt,
    output logic             o_last
);
    localparam int IDX_W = bit_cnt_w(WIDTH);
    localparam logic [IDX_W-1:0] c_IDX_MSB = IDX_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_pat;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] w_pat_nxt;
    logic [IDX_W-1:0] w_idx_nxt;

    // Look-ahead select so the registered serial output can show the new bit
    // in the same cycle the index moves, including a same-edge load+start.
    always_comb begin
        w_pat_nxt = i_load ? i_data : r_pat;
        if (i_restart)
            w_idx_nxt = c_IDX_MSB;
        else if (i_step)
            w_idx_nxt = r_idx - IDX_W'(1);
        else
            w_idx_nxt = r_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat <= '0;
            r_idx <= '0;
        end else begin
            r_pat <= w_pat_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    assign o_bit_nxt = w_pat_nxt[w_idx_nxt];
    assign o_last    = (r_idx == '0);

endmodule
`default_nettype wire

// File: rtl/pattern_tx.sv
`default_nettype none
// ============================================================================
// Module : pattern_tx
// Brief  : Serial pattern transmitter, MSB-first, N repetitions with idle gap
// Rev    : 1.0
// ============================================================================
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int WIDTH    = PATTERN_WIDTH,
    parameter int REPEAT_W = 4,
    parameter int GAP      = 2
) (
    input  logic         clk,
    input  logic         reset,
    pattern_tx_if.slave  bus
);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [GAP_W-1:0] c_GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    state_t              r_state, w_state_nxt;
    logic [REPEAT_W-1:0] r_rep_cfg, r_rep_left, w_rep_left_nxt;
    logic [GAP_W-1:0]    r_gap, w_gap_nxt;
    logic                w_load_en, w_restart, w_step, w_bit_nxt, w_last;
    logic                w_out_nxt, w_valid_nxt, w_busy_nxt, w_done_nxt;
    logic                r_out, r_valid, r_busy, r_done;

    assign w_load_en = bus.load && (r_state == ST_IDLE);

    pattern_tx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load_en),
        .i_data    (bus.patternIn),
        .i_restart (w_restart),
        .i_step    (w_step),
        .o_bit_nxt (w_bit_nxt),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rep_cfg  <= '0;
            r_rep_left <= '0;
            r_gap      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rep_left <= w_rep_left_nxt;
            r_gap      <= w_gap_nxt;
            if (w_load_en)
                r_rep_cfg <= bus.repeat_cnt;
        end
    end

    // r_rep_left counts repetitions still to go after the current one, so
    // an all-ones repeat count yields 2^REPEAT_W bursts without wrapping.
    always_comb begin
        w_state_nxt    = r_state;
        w_rep_left_nxt = r_rep_left;
        w_gap_nxt      = r_gap;
        w_restart      = 1'b0;
        w_step         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt    = ST_SEND;
                    w_restart      = 1'b1;
                    w_rep_left_nxt = w_load_en ? bus.repeat_cnt : r_rep_cfg;
                end
            end
            ST_SEND: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_last) begin
                    w_step = 1'b1;
                end else if (r_rep_left != '0) begin
                    w_rep_left_nxt = r_rep_left - REPEAT_W'(1);
                    if (GAP > 0) begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = c_GAP_LAST;
                    end else begin
                        w_restart = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_gap == '0) begin
                    w_state_nxt = ST_SEND;
                    w_restart   = 1'b1;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_valid_nxt = (w_state_nxt == ST_SEND);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_out_nxt   = w_valid_nxt & w_bit_nxt;
        w_done_nxt  = (r_state == ST_SEND) && !bus.abort && w_last
                      && (r_rep_left == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.serial_out   = r_out;
    assign bus.serial_valid = r_valid;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: doc/pattern_tx.md
# pattern_tx

Serial pattern transmitter, the transmit-side counterpart of the serial pattern detector. Holds a loaded WIDTH-bit pattern and shifts it out MSB-first on a one-bit serial line, a programmable number of times, with a fixed idle gap between repetitions. Used as a stimulus source feeding the detector's serial input and as a standalone pattern generator on the serial link.

## Interface

Parameters:
- WIDTH, 5, pattern length in bits (≥2)
- REPEAT_W, 4, width of the repeat-count field
- GAP, 2, idle cycles between consecutive repetitions (0 allowed)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  capture patternIn/repeat_cnt (honoured in IDLE only)
- patternIn  input  WIDTH  pattern to transmit, MSB sent first
- repeat_cnt  input  REPEAT_W  transmissions = repeat_cnt + 1
- start  input  1  begin transmission (honoured in IDLE only)
- abort  input  1  synchronous abort of an active transmission
- serial_out  output  1  serial data, 0 when not valid
- serial_valid  output  1  high while serial_out carries a pattern bit
- busy  output  1  high in SEND and GAP
- done  output  1  one-cycle pulse after the final bit of the final repetition

## Operation

- All outputs registered. Reset value: serial_out=0, serial_valid=0, busy=0, done=0; pattern and repeat registers cleared; state IDLE.
- States: IDLE, SEND, GAP.
- IDLE: load=1 captures patternIn and repeat_cnt. start=1 → SEND. load and start high together: start uses the newly loaded values. start with nothing loaded since reset transmits all-zero bits; this is legal.
- SEND: bit counter runs WIDTH-1 down to 0; serial_out = pattern[bit], serial_valid=1. After bit 0:
  - repetitions remain and GAP>0 → GAP
  - repetitions remain and GAP=0 → SEND, restart at MSB with no bubble
  - last repetition → IDLE with done=1
- GAP: serial_out=0, serial_valid=0, busy=1 for exactly GAP cycles → SEND.
- load and start are ignored in SEND and GAP. Pattern registers are stable for the whole burst.
- abort=1 in SEND or GAP: at the next edge, go to IDLE with serial_valid=0, serial_out=0, busy=0. No done pulse. abort in IDLE has no effect. abort and start high together in IDLE: start wins.
- Repeat counter is REPEAT_W bits and decrements once per completed repetition. repeat_cnt = all-ones gives 2^REPEAT_W transmissions, with no wrap.
- Asynchronous reset mid-burst forces all outputs and state to their reset values immediately.

## Timing

- start sampled high at edge k → first bit (MSB) is visible from edge k, so busy=1 and serial_valid=1 during cycle k.
- Bit i of a repetition appears WIDTH-1-i cycles after that repetition's MSB.
- Repetition r (0-based) starts at edge k + r·(WIDTH+GAP).
- With N = repeat_cnt+1, done=1 and busy=0 during the single cycle starting at edge k + N·WIDTH + (N-1)·GAP.
- start high in that done cycle is accepted: the next burst starts at that edge +1, giving a minimum 1-cycle idle between bursts.
- load captured at edge k is visible to a start at edge k (same edge) or any later edge.

## Structure

- Shared package pattern_pkg holds:
  - the state enum (IDLE, SEND, GAP)
  - the default pattern width constant, also used by the detector
  - a localparam for the bit-counter width, $clog2(WIDTH)
- One sub-module: pattern_tx_shreg, a WIDTH-bit loadable register with bit-index select and restart-at-MSB control. The FSM, repeat counter and gap counter stay in pattern_tx.

## Test plan

- Reset, load 5'b11011, repeat_cnt=0, start → serial_out 1,1,0,1,1 on 5 consecutive cycles with valid=1; done=1 on cycle 6, busy=0 on cycle 6.
- Load 5'b10010, repeat_cnt=2, GAP=2 → three bursts 10010 separated by 2 cycles of valid=0/serial_out=0; done at cycle 3·5+2·2 = 19 after start.
- GAP=0, repeat_cnt=1, pattern 5'b10001 → 10 valid cycles 1000110001 with no bubble; single done pulse.
- Mid-burst abort on bit 3 → valid drops next cycle, no done. Load/start issued while busy is ignored: the pattern is unchanged on the next start.
- Loopback: serial_out gated by serial_valid drives the detector serial input, both loaded with 11011, repeat_cnt=3 → detector patt pulses once per repetition.
- Asynchronous reset asserted mid-SEND, between clock edges → all outputs 0 immediately; start after reset release transmits zeros (pattern cleared).
